// File: rtl/core_pkg.sv
// Shared types and constants for the RV32I core.
// Pipeline sequencer states live here.
package core_pkg;

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    REDIRECT
  } hazard_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int         IMEM_LAT = 1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: load-use, redirect flush and dmem freeze.
// Drives stall/squash of IF, ID, EX and MA stages.
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic             id_valid_i,
  input  logic [4:0]       id_rs1_addr_i,
  input  logic             id_rs1_used_i,
  input  logic [4:0]       id_rs2_addr_i,
  input  logic             id_rs2_used_i,
  input  logic             id_jal_i,
  input  logic             ex_valid_i,
  input  logic             ex_reg_wr_en_i,
  input  logic [4:0]       ex_reg_wr_addr_i,
  input  logic             ex_intlk_i,
  input  logic             ex_redirect_i,
  input  logic             ma_req_i,
  input  logic             ma_ack_i,
  output logic             stall_if_o,
  output logic             stall_id_o,
  output logic             stall_ex_o,
  output logic             stall_ma_o,
  output logic             squash_if_o,
  output logic             squash_id_o,
  output logic             mem_err_o,
  output logic [CNT_W-1:0] perf_stall_cnt_o,
  output logic [CNT_W-1:0] perf_flush_cnt_o
);

  localparam logic [15:0] TO_LAST = 16'(MEM_TIMEOUT - 1);

  hazard_state_t state_q, state_d;
  logic [15:0]   wait_q, wait_d;
  logic          pend_q, pend_d;

  logic ex_red, rs1_hit, rs2_hit, load_use;
  logic in_wait, mem_busy, timeout;
  logic freeze, sq_if, sq_id, bubble;

  assign ex_red  = ex_redirect_i && ex_valid_i;
  assign rs1_hit = id_rs1_used_i
                && (id_rs1_addr_i == ex_reg_wr_addr_i);
  assign rs2_hit = id_rs2_used_i
                && (id_rs2_addr_i == ex_reg_wr_addr_i);

  assign load_use = id_valid_i && ex_valid_i
                 && ex_intlk_i && ex_reg_wr_en_i
                 && (ex_reg_wr_addr_i != REG_ZERO)
                 && (rs1_hit || rs2_hit);

  assign in_wait  = (state_q == MEM_WAIT);
  assign mem_busy = in_wait ? !ma_ack_i
                            : (ma_req_i && !ma_ack_i);
  assign timeout  = in_wait && !ma_ack_i
                 && (wait_q >= TO_LAST);

  always_comb begin
    freeze = 1'b0;
    sq_if  = 1'b0;
    sq_id  = 1'b0;
    bubble = 1'b0;
    if (mem_busy) begin
      freeze = 1'b1;
    end else if (ex_red) begin
      sq_if = 1'b1;
      sq_id = 1'b1;
    end else if (id_jal_i) begin
      sq_if = 1'b1;
    end else begin
      // REDIRECT covers the fetch already in flight
      sq_if  = (state_q == REDIRECT);
      bubble = load_use;
      sq_id  = load_use;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    pend_d  = pend_q;
    unique case (state_q)
      MEM_WAIT: begin
        if (ma_ack_i || timeout) begin
          wait_d  = '0;
          pend_d  = 1'b0;
          state_d = ((ex_red && ma_ack_i) || pend_q)
                  ? REDIRECT : RUN;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      default: begin
        if (ma_req_i && !ma_ack_i) begin
          state_d = MEM_WAIT;
          wait_d  = 16'd1;
          pend_d  = (state_q == REDIRECT);
        end else if (ex_red) begin
          state_d = REDIRECT;
        end else begin
          state_d = RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RUN;
      wait_q  <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      pend_q  <= pend_d;
    end
  end

  assign stall_if_o  = rst_ni && (freeze || bubble);
  assign stall_id_o  = rst_ni && freeze;
  assign stall_ex_o  = rst_ni && freeze;
  assign stall_ma_o  = rst_ni && freeze;
  assign squash_if_o = rst_ni && sq_if;
  assign squash_id_o = rst_ni && sq_id;
  assign mem_err_o   = rst_ni && timeout;

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk    (clk),
    .rst_ni (rst_ni),
    .clr    (1'b0),
    .inc    (stall_if_o),
    .count  (perf_stall_cnt_o)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk    (clk),
    .rst_ni (rst_ni),
    .clr    (1'b0),
    .inc    (!mem_busy && (ex_red || id_jal_i)),
    .count  (perf_flush_cnt_o)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl with directed vectors.
// Output order: stall if/id/ex/ma, squash if/id, mem_err.
module tb_hazard_ctrl;

  typedef struct packed {
    logic       id_valid;
    logic [4:0] rs1;
    logic       rs1_used;
    logic [4:0] rs2;
    logic       rs2_used;
    logic       jal;
    logic       ex_valid;
    logic       wr_en;
    logic [4:0] rd;
    logic       intlk;
    logic       redir;
    logic       req;
    logic       ack;
  } stim_t;

  typedef struct {
    logic [6:0] o;
    bit         chk;
    int         sc;
    int         fc;
    string      name;
  } exp_t;

  localparam logic [6:0] IDLE = 7'b0000000;
  localparam logic [6:0] FRZ  = 7'b1111000;
  localparam logic [6:0] BUB  = 7'b1000010;
  localparam logic [6:0] RED  = 7'b0000110;
  localparam logic [6:0] SQIF = 7'b0000100;
  localparam logic [6:0] ERR  = 7'b1111001;

  logic clk = 1'b0;
  logic rst_ni;
  stim_t s;
  logic stall_if, stall_id, stall_ex, stall_ma;
  logic squash_if, squash_id, mem_err;
  logic [31:0] sc, fc;

  exp_t sb[$];
  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(32), .MEM_TIMEOUT(4)) dut (
    .clk              (clk),
    .rst_ni           (rst_ni),
    .id_valid_i       (s.id_valid),
    .id_rs1_addr_i    (s.rs1),
    .id_rs1_used_i    (s.rs1_used),
    .id_rs2_addr_i    (s.rs2),
    .id_rs2_used_i    (s.rs2_used),
    .id_jal_i         (s.jal),
    .ex_valid_i       (s.ex_valid),
    .ex_reg_wr_en_i   (s.wr_en),
    .ex_reg_wr_addr_i (s.rd),
    .ex_intlk_i       (s.intlk),
    .ex_redirect_i    (s.redir),
    .ma_req_i         (s.req),
    .ma_ack_i         (s.ack),
    .stall_if_o       (stall_if),
    .stall_id_o       (stall_id),
    .stall_ex_o       (stall_ex),
    .stall_ma_o       (stall_ma),
    .squash_if_o      (squash_if),
    .squash_id_o      (squash_id),
    .mem_err_o        (mem_err),
    .perf_stall_cnt_o (sc),
    .perf_flush_cnt_o (fc)
  );

  function automatic logic [6:0] outs();
    return {stall_if, stall_id, stall_ex, stall_ma,
            squash_if, squash_id, mem_err};
  endfunction

  function automatic stim_t lu(
    input logic [4:0] rd, input logic [4:0] rs1,
    input logic u1, input logic [4:0] rs2,
    input logic u2, input logic intlk);
    stim_t t = '0;
    t.id_valid = 1'b1;
    t.rs1 = rs1;  t.rs1_used = u1;
    t.rs2 = rs2;  t.rs2_used = u2;
    t.ex_valid = 1'b1;
    t.wr_en = 1'b1;
    t.rd = rd;    t.intlk = intlk;
    return t;
  endfunction

  function automatic stim_t mem(
    input logic req, input logic ack, input logic red);
    stim_t t = '0;
    t.req = req;  t.ack = ack;
    t.ex_valid = red;  t.redir = red;
    return t;
  endfunction

  function automatic stim_t jal();
    stim_t t = '0;
    t.jal = 1'b1;
    return t;
  endfunction

  task automatic step(input stim_t st, input logic [6:0] o,
                      input string n, input bit chk = 0,
                      input int esc = 0, input int efc = 0);
    exp_t e;
    @(posedge clk);
    #1;
    s = st;
    e.o = o;  e.chk = chk;
    e.sc = esc;  e.fc = efc;  e.name = n;
    sb.push_back(e);
  endtask

  task automatic check_now(input string n,
                           input logic [6:0] o,
                           input int esc, input int efc);
    tests_run++;
    if (outs() !== o || sc !== esc || fc !== efc) begin
      tests_failed++;
      $display("FAIL %s: got o=%b sc=%0d fc=%0d want o=%b sc=%0d fc=%0d",
               n, outs(), sc, fc, o, esc, efc);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      tests_run++;
      if (outs() !== e.o) begin
        tests_failed++;
        $display("FAIL %s outputs: got %b want %b",
                 e.name, outs(), e.o);
      end
      if (e.chk) begin
        tests_run++;
        if (sc !== e.sc || fc !== e.fc) begin
          tests_failed++;
          $display("FAIL %s counters: got sc=%0d fc=%0d want sc=%0d fc=%0d",
                   e.name, sc, fc, e.sc, e.fc);
        end
      end
    end
  end

  initial begin
    s = mem(1'b1, 1'b0, 1'b1);
    rst_ni = 1'b0;
    #3;
    check_now("in_reset", IDLE, 0, 0);
    #4;
    s = '0;
    #15 rst_ni = 1'b1;

    step(lu(5'd5, 5'd1, 1'b1, 5'd5, 1'b1, 1'b1), BUB, "lu_rs2");
    step(lu(5'd5, 5'd1, 1'b1, 5'd5, 1'b1, 1'b0), IDLE,
         "lu_done", 1, 1, 0);
    step(lu(5'd7, 5'd7, 1'b0, 5'd7, 1'b0, 1'b1), IDLE, "lu_unused");
    step(lu(5'd7, 5'd1, 1'b1, 5'd7, 1'b1, 1'b0), IDLE, "lu_fwd");
    step(lu(5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1), IDLE,
         "lu_x0", 1, 1, 0);
    step(lu(5'd9, 5'd9, 1'b1, 5'd2, 1'b0, 1'b1), BUB, "lu_rs1");

    step(mem(1'b0, 1'b0, 1'b1), RED,  "red_n");
    step(mem(1'b0, 1'b0, 1'b0), SQIF, "red_n1");
    step(mem(1'b0, 1'b0, 1'b0), IDLE, "red_n2", 1, 2, 1);

    step(jal(), SQIF, "jal");
    step(mem(1'b0, 1'b0, 1'b0), IDLE, "jal_after", 1, 2, 2);
    begin
      stim_t t;
      t = lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1);
      t.jal = 1'b1;
      step(t, SQIF, "jal_over_lu");
    end
    step(mem(1'b0, 1'b0, 1'b0), IDLE, "jal_lu_after", 1, 2, 3);

    step(mem(1'b1, 1'b0, 1'b1), FRZ,  "frz_1");
    step(mem(1'b1, 1'b0, 1'b1), FRZ,  "frz_2");
    step(mem(1'b1, 1'b0, 1'b1), FRZ,  "frz_3");
    step(mem(1'b1, 1'b1, 1'b1), RED,  "frz_ack_red");
    step(mem(1'b0, 1'b0, 1'b0), SQIF, "frz_red_n1");
    step(mem(1'b0, 1'b0, 1'b0), IDLE, "frz_done", 1, 5, 4);

    step(mem(1'b1, 1'b0, 1'b0), FRZ,  "to_1");
    step(mem(1'b1, 1'b0, 1'b0), FRZ,  "to_2");
    step(mem(1'b1, 1'b0, 1'b0), FRZ,  "to_3");
    step(mem(1'b1, 1'b0, 1'b0), ERR,  "to_4_err");
    step(mem(1'b0, 1'b0, 1'b0), IDLE, "to_run", 1, 9, 4);

    step(mem(1'b0, 1'b0, 1'b1), RED,  "pend_red");
    step(mem(1'b1, 1'b0, 1'b0), FRZ,  "pend_frz");
    step(mem(1'b1, 1'b1, 1'b0), IDLE, "pend_ack");
    step(mem(1'b0, 1'b0, 1'b0), SQIF, "pend_replay");
    step(mem(1'b0, 1'b0, 1'b0), IDLE, "pend_done", 1, 10, 5);

    step(mem(1'b1, 1'b1, 1'b0), IDLE, "req_ack_same", 1, 10, 5);

    step(mem(1'b0, 1'b0, 1'b1), RED,  "rst_red_a");
    step(mem(1'b0, 1'b0, 1'b1), RED,  "restart_red");
    step(mem(1'b0, 1'b0, 1'b0), SQIF, "restart_n1");
    step(mem(1'b0, 1'b0, 1'b0), IDLE, "restart_done", 1, 10, 7);

    step(mem(1'b1, 1'b0, 1'b0), FRZ, "rst_frz_a");
    step(mem(1'b1, 1'b0, 1'b0), FRZ, "rst_frz_b");
    @(negedge clk);
    #2 rst_ni = 1'b0;
    #1 check_now("async_rst", IDLE, 0, 0);
    @(negedge clk);
    s = '0;
    #1 rst_ni = 1'b1;
    step(mem(1'b0, 1'b0, 1'b0), IDLE, "post_rst", 1, 0, 0);
    step(mem(1'b0, 1'b0, 1'b0), IDLE, "post_rst_run", 1, 0, 0);

    for (int i = 0; i < 10 && sb.size() > 0; i++)
      @(posedge clk);
    if (sb.size() > 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed",
             tests_run, tests_failed);
    $finish;
  end

endmodule
